rtc_timekeeper: RTL
===================

// Module: rtc_timekeeper
// PURPOSE
//  Parametrised 24-hour time-of-day counter: prescales clk to a 1 Hz tick and advances hh:mm:ss.
//  Runtime load, run/hold, per-field adjust and rollover strobes.
//  Feeds display, alarm-compare and user-input logic of the alarm clock.
// PARAMETERS
//  CLK_DIV  50_000_000           clk cycles per second tick; >=2
//  CNT_W    $clog2(CLK_DIV)      prescaler width (derived, not overridden)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  run         in   1  1 = count, 0 = hold (prescaler and time frozen)
//  load        in   1  one-cycle request to set time from load_* fields
//  load_hour   in   8  0..23
//  load_minute in   8  0..59
//  load_second in   8  0..59
//  inc_minute  in   1  one-cycle pulse: minute+1, wraps 59->0, no carry into hour
//  inc_hour    in   1  one-cycle pulse: hour+1, wraps 23->0
//  current_hour   out 8  0..23
//  current_minute out 8  0..59
//  current_second out 8  0..59
//  sec_tick    out  1  one-cycle strobe when second advances from prescaler
//  min_wrap    out  1  one-cycle strobe when second 59->0 via tick
//  day_wrap    out  1  one-cycle strobe when 23:59:59 -> 00:00:00 via tick
//  load_err    out  1  one-cycle strobe: load rejected (field out of range)
// BEHAVIOUR
//  - Reset (async assert, sync release): time 00:00:00, prescaler 0, all strobes 0.
//  - Prescaler counts 0..CLK_DIV-1 while run=1; terminal count -> tick, wraps to 0.
//  - Tick period is exactly CLK_DIV cycles.
//  - Tick: second+1; 59->0 carries to minute; minute 59->0 carries to hour; hour 23->0.
//  - All outputs registered; a tick edge updates time and raises strobes on the same clk edge.
//  - Priority per cycle: load > inc_hour/inc_minute > tick.
//  - load valid (h<24, m<60, s<60): time := load values next edge; prescaler := 0; no strobes.
//  - load invalid: time and prescaler unchanged; load_err=1 for one cycle.
//  - load acts regardless of run.
//  - inc_minute and inc_hour in the same cycle both apply. They act regardless of run.
//  - Adjust does not touch second or the prescaler and raises no strobes.
//  - Adjust coincident with terminal count: tick deferred; prescaler holds at CLK_DIV-1.
//  - The deferred tick fires on the next cycle without an adjust (if run=1). No second lost.
//  - Load coincident with terminal count: tick discarded (load wins, prescaler cleared).
//  - run=0 at terminal count: no tick; prescaler holds; the tick fires on the first run=1 cycle.
//  - Arithmetic is unsigned 8-bit; out-of-range field values are unreachable by construction.
//  - rst_n low mid-second: time and prescaler cleared immediately; no strobe emitted.
// CONFIGURATION
//  TWELVE_HOUR_EN defined: adds outputs disp_hour [7:0] (1..12) and pm [0] (1 when hour>=12).
//   - Mapping: hour 0 -> 12 AM, hour 12 -> 12 PM, hour 13 -> 1 PM.
//   - Registered alongside time; reset values disp_hour=12, pm=0.
//  Undefined: ports absent; core 24-hour counter unchanged.
// TESTING (CLK_DIV=4 unless noted)
//  - Reset then run=1 for 12 cycles -> sec_tick every 4th cycle; current_second 0->1->2->3.
//  - load 23:59:58, run=1 -> after 8 cycles 00:00:00.
//  - Same run: min_wrap and day_wrap high exactly one cycle, coincident with the 00:00:00 update.
//  - load 24:00:00 -> load_err one cycle; time unchanged.
//  - Follow with load 12:30:45 -> time 12:30:45; prescaler 0; first tick 4 cycles later.
//  - inc_minute at 10:59:30 -> 10:00:30 (no hour carry).
//  - inc_minute coincident with terminal count -> minute+1 that edge; second+1 on the next edge.
//  - run=0 for 20 cycles -> no change.
//  - rst_n pulsed low mid-count -> outputs 00:00:00 asynchronously.
//  - With TWELVE_HOUR_EN: load 00:00:00 -> disp_hour=12, pm=0.
//  - Same build: load 13:05:00 -> disp_hour=1, pm=1.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// 24-hour hh:mm:ss time-of-day counter with a CLK_DIV prescaler, load, run/hold and field adjust.
// Optional 12-hour display outputs (disp_hour, pm) are enabled by defining TWELVE_HOUR_EN.
module rtc_timekeeper #(
    parameter int CLK_DIV = 50_000_000,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_minute,
    input  logic [7:0] load_second,
    input  logic       inc_minute,
    input  logic       inc_hour,
    output logic [7:0] current_hour,
    output logic [7:0] current_minute,
    output logic [7:0] current_second,
    output logic       sec_tick,
    output logic       min_wrap,
    output logic       day_wrap,
    output logic       load_err
`ifdef TWELVE_HOUR_EN
    ,
    output logic [7:0] disp_hour,
    output logic       pm
`endif
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] presc_reg, presc_next;
    logic [7:0]       hour_reg, hour_next;
    logic [7:0]       minute_reg, minute_next;
    logic [7:0]       second_reg, second_next;
    logic             sec_tick_reg, sec_tick_next;
    logic             min_wrap_reg, min_wrap_next;
    logic             day_wrap_reg, day_wrap_next;
    logic             load_err_reg, load_err_next;
    logic             load_ok;
    logic             adjust;
    logic             at_term;

    always_comb begin
        presc_next    = presc_reg;
        hour_next     = hour_reg;
        minute_next   = minute_reg;
        second_next   = second_reg;
        sec_tick_next = 1'b0;
        min_wrap_next = 1'b0;
        day_wrap_next = 1'b0;
        load_err_next = 1'b0;

        load_ok = (load_hour < 8'd24) && (load_minute < 8'd60) && (load_second < 8'd60);
        adjust  = inc_hour | inc_minute;
        at_term = (presc_reg == TERM);

        if (load) begin
            if (load_ok) begin
                hour_next   = load_hour;
                minute_next = load_minute;
                second_next = load_second;
                presc_next  = '0;
            end else begin
                load_err_next = 1'b1;
            end
        end else begin
            if (inc_minute)
                minute_next = (minute_reg == 8'd59) ? 8'd0 : minute_reg + 8'd1;
            if (inc_hour)
                hour_next = (hour_reg == 8'd23) ? 8'd0 : hour_reg + 8'd1;

            // An adjust at terminal count parks the prescaler so the tick fires one cycle later.
            if (run) begin
                if (!at_term) begin
                    presc_next = presc_reg + 1'b1;
                end else if (!adjust) begin
                    presc_next    = '0;
                    sec_tick_next = 1'b1;
                    if (second_reg == 8'd59) begin
                        second_next   = 8'd0;
                        min_wrap_next = 1'b1;
                        if (minute_reg == 8'd59) begin
                            minute_next = 8'd0;
                            if (hour_reg == 8'd23) begin
                                hour_next     = 8'd0;
                                day_wrap_next = 1'b1;
                            end else begin
                                hour_next = hour_reg + 8'd1;
                            end
                        end else begin
                            minute_next = minute_reg + 8'd1;
                        end
                    end else begin
                        second_next = second_reg + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg    <= '0;
            hour_reg     <= 8'd0;
            minute_reg   <= 8'd0;
            second_reg   <= 8'd0;
            sec_tick_reg <= 1'b0;
            min_wrap_reg <= 1'b0;
            day_wrap_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            hour_reg     <= hour_next;
            minute_reg   <= minute_next;
            second_reg   <= second_next;
            sec_tick_reg <= sec_tick_next;
            min_wrap_reg <= min_wrap_next;
            day_wrap_reg <= day_wrap_next;
            load_err_reg <= load_err_next;
        end
    end

    assign current_hour   = hour_reg;
    assign current_minute = minute_reg;
    assign current_second = second_reg;
    assign sec_tick       = sec_tick_reg;
    assign min_wrap       = min_wrap_reg;
    assign day_wrap       = day_wrap_reg;
    assign load_err       = load_err_reg;

`ifdef TWELVE_HOUR_EN
    logic [7:0] disp_hour_reg, disp_hour_next;
    logic       pm_reg, pm_next;

    // Derived from hour_next so the 12-hour view changes on the same edge as the time.
    always_comb begin
        disp_hour_next = hour_next;
        pm_next        = (hour_next >= 8'd12);
        if (hour_next == 8'd0)
            disp_hour_next = 8'd12;
        else if (hour_next > 8'd12)
            disp_hour_next = hour_next - 8'd12;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_hour_reg <= 8'd12;
            pm_reg        <= 1'b0;
        end else begin
            disp_hour_reg <= disp_hour_next;
            pm_reg        <= pm_next;
        end
    end

    assign disp_hour = disp_hour_reg;
    assign pm        = pm_reg;
`endif

endmodule
